mp_2d_ram: RTL and testbench

Multi-read-port, single-write-port register-array RAM with byte enables, configurable read latency, per-port output backpressure and a hardware memory-clear sequence after reset. It replaces single-port scratch RAMs wherever several consumers read a shared table that one producer updates, such as weight and feature buffers feeding parallel compute lanes.

---
 rtl/mp_2d_ram_if.sv | 34 +++
 rtl/mp_2d_ram.sv | 132 +++++++++++++
 tb/tb_mp_2d_ram.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mp_2d_ram_if.sv
// Bus bundle for mp_2d_ram: one write channel, N_RD packed read channels
// with per-port return backpressure, plus status flags.
interface mp_2d_ram_if #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  parameter int N_RD  = 2
);
  localparam int ADDR_LEN = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BE_W     = WIDTH / 8;

  logic                     init_done;
  logic                     addr_err;
  logic                     wr_valid;
  logic                     wr_ready;
  logic [ADDR_LEN-1:0]      wr_addr;
  logic [WIDTH-1:0]         wr_data;
  logic [BE_W-1:0]          wr_be;
  logic [N_RD-1:0]          rd_valid;
  logic [N_RD-1:0]          rd_ready;
  logic [N_RD*ADDR_LEN-1:0] rd_addr;
  logic [N_RD*WIDTH-1:0]    rd_data;
  logic [N_RD-1:0]          rd_data_valid;
  logic [N_RD-1:0]          rd_data_ready;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_be, rd_valid, rd_addr, rd_data_ready,
    input  wr_ready, rd_ready, rd_data, rd_data_valid, init_done, addr_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_be, rd_valid, rd_addr, rd_data_ready,
    output wr_ready, rd_ready, rd_data, rd_data_valid, init_done, addr_err
  );
endinterface

// File: rtl/mp_2d_ram.sv
// Multi-read, single-write register-array RAM with byte enables, per-port
// stallable read pipelines and a zeroing sweep after reset.
module mp_2d_ram #(
  parameter int DEPTH   = 32,
  parameter int WIDTH   = 32,
  parameter int N_RD    = 2,
  parameter int RD_LAT  = 1,
  parameter int WR_MODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  mp_2d_ram_if.slave bus
);
  localparam int ADDR_LEN = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BE_W     = WIDTH / 8;
  localparam logic [ADDR_LEN:0]   L_DEPTH = (ADDR_LEN + 1)'(DEPTH);
  localparam logic [ADDR_LEN-1:0] L_LAST  = ADDR_LEN'(DEPTH - 1);
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]          r_state;
  logic [ADDR_LEN-1:0] r_clr_cnt;
  logic                r_init_done;
  logic                r_addr_err;
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [RD_LAT-1:0]   r_vld [N_RD];
  logic [WIDTH-1:0]    r_dat [N_RD][RD_LAT];

  logic                w_run;
  logic                w_wr_acc;
  logic                w_wr_oor;
  logic                w_rd_oor_any;
  logic [N_RD-1:0]     w_stall;
  logic [N_RD-1:0]     w_rd_acc;
  logic [N_RD-1:0]     w_rd_ready;
  logic [N_RD-1:0]     w_rd_dvld;
  logic [WIDTH-1:0]    w_rd_word [N_RD];
  logic [N_RD*WIDTH-1:0] w_rd_data;

  function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] old_w,
                                               input logic [WIDTH-1:0] new_w,
                                               input logic [BE_W-1:0]  be);
    logic [WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    return res;
  endfunction

  function automatic logic f_oor(input logic [ADDR_LEN-1:0] a);
    return {1'b0, a} >= L_DEPTH;
  endfunction

  assign w_run    = (r_state == S_RUN);
  assign w_wr_acc = bus.wr_valid && w_run;
  assign w_wr_oor = f_oor(bus.wr_addr);

  // Read-side combinational: stall, accept and the word captured into stage 1
  always_comb begin
    w_stall      = '0;
    w_rd_ready   = '0;
    w_rd_acc     = '0;
    w_rd_dvld    = '0;
    w_rd_data    = '0;
    w_rd_oor_any = 1'b0;
    for (int p = 0; p < N_RD; p++) begin
      w_stall[p]    = r_vld[p][RD_LAT-1] && !bus.rd_data_ready[p];
      w_rd_ready[p] = w_run && !w_stall[p];
      w_rd_acc[p]   = bus.rd_valid[p] && w_rd_ready[p];
      w_rd_dvld[p]  = r_vld[p][RD_LAT-1];
      w_rd_data[p*WIDTH +: WIDTH] = r_dat[p][RD_LAT-1];
      w_rd_word[p]  = '0;
      if (!f_oor(bus.rd_addr[p*ADDR_LEN +: ADDR_LEN])) begin
        w_rd_word[p] = r_mem[bus.rd_addr[p*ADDR_LEN +: ADDR_LEN]];
        // Write-first bypass merges only the bytes being written this cycle
        if (WR_MODE == 1 && w_wr_acc && bus.wr_addr == bus.rd_addr[p*ADDR_LEN +: ADDR_LEN])
          w_rd_word[p] = f_merge(w_rd_word[p], bus.wr_data, bus.wr_be);
      end else if (w_rd_acc[p]) begin
        w_rd_oor_any = 1'b1;
      end
    end
  end

  // Control: clear sweep, init flag, sticky address error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_CLEAR;
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_init_done <= w_run;
      if (!w_run) begin
        r_clr_cnt <= r_clr_cnt + ADDR_LEN'(1);
        if (r_clr_cnt == L_LAST) r_state <= S_RUN;
      end
      if ((w_wr_acc && w_wr_oor) || w_rd_oor_any) r_addr_err <= 1'b1;
    end
  end

  // Storage: zeroed one word per cycle during the sweep, byte-merged writes after
  always_ff @(posedge clk) begin
    if (!w_run)
      r_mem[r_clr_cnt] <= '0;
    else if (w_wr_acc && !w_wr_oor)
      r_mem[bus.wr_addr] <= f_merge(r_mem[bus.wr_addr], bus.wr_data, bus.wr_be);
  end

  // Read pipelines: stage 1 captures at accept, later stages shift; a stalled port freezes whole
  always_ff @(posedge clk) begin
    for (int p = 0; p < N_RD; p++) begin
      if (!rst_n) begin
        r_vld[p] <= '0;
        for (int s = 0; s < RD_LAT; s++) r_dat[p][s] <= '0;
      end else if (!w_stall[p]) begin
        r_vld[p][0] <= w_rd_acc[p];
        r_dat[p][0] <= w_rd_acc[p] ? w_rd_word[p] : '0;
        for (int s = 1; s < RD_LAT; s++) begin
          r_vld[p][s] <= r_vld[p][s-1];
          r_dat[p][s] <= r_dat[p][s-1];
        end
      end
    end
  end

  assign bus.wr_ready      = w_run;
  assign bus.rd_ready      = w_rd_ready;
  assign bus.rd_data       = w_rd_data;
  assign bus.rd_data_valid = w_rd_dvld;
  assign bus.init_done     = r_init_done;
  assign bus.addr_err      = r_addr_err;
endmodule

// File: tb/tb_mp_2d_ram.sv
// Bench for mp_2d_ram: read-first and write-first instances share stimulus and
// are checked every cycle against a queue-of-reads model, plus literal spot checks.
module tb_mp_2d_ram;
  localparam int DEPTH  = 20;
  localparam int WIDTH  = 32;
  localparam int N_RD   = 2;
  localparam int RD_LAT = 3;
  localparam int AL     = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_wr_valid = 1'b0;
  logic [4:0]  s_wr_addr = '0;
  logic [31:0] s_wr_data = '0;
  logic [3:0]  s_wr_be = '0;
  logic [1:0]  s_rd_valid = '0;
  logic [9:0]  s_rd_addr = '0;
  logic [1:0]  s_rd_dready = '1;

  mp_2d_ram_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .N_RD(N_RD)) b0 ();
  mp_2d_ram_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .N_RD(N_RD)) b1 ();

  assign b0.wr_valid = s_wr_valid;    assign b1.wr_valid = s_wr_valid;
  assign b0.wr_addr = s_wr_addr;      assign b1.wr_addr = s_wr_addr;
  assign b0.wr_data = s_wr_data;      assign b1.wr_data = s_wr_data;
  assign b0.wr_be = s_wr_be;          assign b1.wr_be = s_wr_be;
  assign b0.rd_valid = s_rd_valid;    assign b1.rd_valid = s_rd_valid;
  assign b0.rd_addr = s_rd_addr;      assign b1.rd_addr = s_rd_addr;
  assign b0.rd_data_ready = s_rd_dready; assign b1.rd_data_ready = s_rd_dready;

  mp_2d_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .N_RD(N_RD), .RD_LAT(RD_LAT), .WR_MODE(0))
    u_rf (.clk(clk), .rst_n(rst_n), .bus(b0));
  mp_2d_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .N_RD(N_RD), .RD_LAT(RD_LAT), .WR_MODE(1))
    u_wf (.clk(clk), .rst_n(rst_n), .bus(b1));

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: memory array, cycles since reset release, in-flight reads with ages
  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    int          age;
  } item_t;

  logic [31:0] m_mem [DEPTH];
  int          m_edges = 0;
  logic        m_err = 1'b0;
  item_t       m_fl [N_RD][RD_LAT+1];
  int          m_n [N_RD];
  logic [1:0]  m_zero = '1;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic m_run();
    return m_edges >= DEPTH;
  endfunction

  function automatic logic m_vld(input int p);
    return (m_n[p] > 0) && (m_fl[p][0].age == RD_LAT);
  endfunction

  always @(posedge clk) begin
    logic        run, wacc, stl, racc;
    int          a, wa;
    logic [31:0] old;
    if (!rst_n) begin
      m_edges = 0;
      m_err = 1'b0;
      m_zero = '1;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      for (int p = 0; p < N_RD; p++) m_n[p] = 0;
    end else begin
      run = m_run();
      wa = int'(s_wr_addr);
      wacc = run && s_wr_valid;
      if (wacc && wa >= DEPTH) m_err = 1'b1;
      for (int p = 0; p < N_RD; p++) begin
        a = int'(s_rd_addr[p*AL +: AL]);
        stl = m_vld(p) && !s_rd_dready[p];
        racc = run && s_rd_valid[p] && !stl;
        if (racc && a >= DEPTH) m_err = 1'b1;
        old = (a < DEPTH) ? m_mem[a] : 32'h0;
        if (!stl) begin
          if (m_vld(p)) begin
            for (int k = 1; k < m_n[p]; k++) m_fl[p][k-1] = m_fl[p][k];
            m_n[p]--;
          end
          for (int k = 0; k < m_n[p]; k++) m_fl[p][k].age++;
          if (racc) begin
            m_fl[p][m_n[p]].d0 = old;
            m_fl[p][m_n[p]].d1 = (wacc && wa == a && a < DEPTH) ? merge(old, s_wr_data, s_wr_be) : old;
            m_fl[p][m_n[p]].age = 1;
            m_n[p]++;
            m_zero[p] = 1'b0;
          end
        end
      end
      if (wacc && wa < DEPTH) m_mem[wa] = merge(m_mem[wa], s_wr_data, s_wr_be);
      if (m_edges < DEPTH + 1) m_edges++;
    end
  end

  task automatic cmp(input int m, input logic init, input logic wrr, input logic [1:0] rdr,
                     input logic [1:0] dv, input logic [63:0] rdd, input logic err);
    chk($sformatf("m%0d init_done", m), 32'(init), 32'(m_edges >= DEPTH + 1));
    chk($sformatf("m%0d wr_ready", m), 32'(wrr), 32'(m_run()));
    chk($sformatf("m%0d addr_err", m), 32'(err), 32'(m_err));
    for (int p = 0; p < N_RD; p++) begin
      chk($sformatf("m%0d rd_ready[%0d]", m, p), 32'(rdr[p]),
          32'(m_run() && !(m_vld(p) && !s_rd_dready[p])));
      chk($sformatf("m%0d rd_data_valid[%0d]", m, p), 32'(dv[p]), 32'(m_vld(p)));
      if (m_vld(p))
        chk($sformatf("m%0d rd_data[%0d]", m, p), rdd[p*32 +: 32],
            (m == 0) ? m_fl[p][0].d0 : m_fl[p][0].d1);
      else if (m_zero[p])
        chk($sformatf("m%0d rd_data_rst[%0d]", m, p), rdd[p*32 +: 32], 32'h0);
    end
  endtask

  always @(negedge clk) begin
    cmp(0, b0.init_done, b0.wr_ready, b0.rd_ready, b0.rd_data_valid, b0.rd_data, b0.addr_err);
    cmp(1, b1.init_done, b1.wr_ready, b1.rd_ready, b1.rd_data_valid, b1.rd_data, b1.addr_err);
  end

  // Delivery recorder for the backpressure burst
  logic        rec_en = 1'b0;
  logic [31:0] rec [N_RD][8];
  int          rec_n [N_RD];
  always @(negedge clk) begin
    if (!rec_en) begin
      rec_n[0] = 0;
      rec_n[1] = 0;
    end else begin
      for (int p = 0; p < N_RD; p++)
        if (b0.rd_data_valid[p] && s_rd_dready[p] && rec_n[p] < 8) begin
          rec[p][rec_n[p]] = b0.rd_data[p*32 +: 32];
          rec_n[p]++;
        end
    end
  end

  logic [31:0] g0 [8];
  logic [31:0] g1 [8];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    s_wr_valid = 1'b1; s_wr_addr = 5'(a); s_wr_data = d; s_wr_be = be;
    tick();
    s_wr_valid = 1'b0;
  endtask

  task automatic rd(input int p, input int a);
    s_rd_valid = 2'(1 << p);
    s_rd_addr[p*AL +: AL] = 5'(a);
    tick();
    s_rd_valid = '0;
  endtask

  task automatic collect(input int p, input int n);
    int got;
    got = 0;
    for (int c = 0; c < 20 && got < n; c++) begin
      if (b0.rd_data_valid[p]) begin
        g0[got] = b0.rd_data[p*32 +: 32];
        g1[got] = b1.rd_data[p*32 +: 32];
        got++;
      end
      tick();
    end
    chk($sformatf("collect p%0d count", p), 32'(got), 32'(n));
  endtask

  task automatic wait_init(input string nm);
    int cyc;
    cyc = 0;
    while (cyc < 60 && !b0.init_done) begin
      tick();
      cyc++;
      if (cyc == 10) begin s_wr_valid = 1'b0; s_rd_valid = '0; end
      if (cyc == 5) begin
        chk({nm, " wr_ready in clear"}, 32'(b0.wr_ready), 32'h0);
        chk({nm, " rd_ready in clear"}, 32'(b1.rd_ready), 32'h0);
      end
    end
    chk({nm, " clear cycles"}, 32'(cyc), 32'(DEPTH + 1));
  endtask

  task automatic random_traffic(input int n);
    for (int c = 0; c < n; c++) begin
      s_wr_valid = 1'($urandom_range(0, 1));
      s_wr_addr = 5'($urandom_range(0, 23));
      s_wr_data = $urandom;
      s_wr_be = 4'($urandom);
      s_rd_valid = 2'($urandom);
      s_rd_addr = {5'($urandom_range(0, 21)), 5'($urandom_range(0, 21))};
      s_rd_dready = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      tick();
    end
    s_wr_valid = 1'b0; s_rd_valid = '0; s_rd_dready = '1;
    repeat (8) tick();
  endtask

  initial begin
    int i0, i1;
    logic a0, a1;
    repeat (3) tick();
    chk("reset init_done", 32'(b0.init_done), 32'h0);
    chk("reset rd_data_valid", 32'(b1.rd_data_valid), 32'h0);
    chk("reset rd_data", b0.rd_data[31:0], 32'h0);

    // Clear sweep with requests that must be ignored
    rst_n = 1'b1;
    s_wr_valid = 1'b1; s_wr_addr = 5'd7; s_wr_data = '1; s_wr_be = '1;
    s_rd_valid = '1; s_rd_addr = {5'd7, 5'd7};
    wait_init("first");

    for (int i = 0; i < DEPTH; i++) begin
      s_rd_valid = 2'b11;
      s_rd_addr = {5'(DEPTH - 1 - i), 5'(i)};
      tick();
    end
    s_rd_valid = '0;
    repeat (6) tick();
    chk("model cleared addr7", m_mem[7], 32'h0);

    // Byte enables
    wr(5, 32'hAABBCCDD, 4'hF);
    wr(5, 32'h11223344, 4'b0101);
    chk("model be merge", m_mem[5], 32'hAA22CC44);
    rd(0, 5);
    collect(0, 1);
    chk("be read rf", g0[0], 32'hAA22CC44);
    chk("be read wf", g1[0], 32'hAA22CC44);

    // Same-cycle collision then a following read
    wr(3, 32'h0, 4'hF);
    s_wr_valid = 1'b1; s_wr_addr = 5'd3; s_wr_data = 32'hDEADBEEF; s_wr_be = 4'hF;
    s_rd_valid = 2'b01; s_rd_addr[4:0] = 5'd3;
    tick();
    s_wr_valid = 1'b0;
    tick();
    s_rd_valid = '0;
    collect(0, 2);
    chk("collision rf", g0[0], 32'h0);
    chk("collision wf", g1[0], 32'hDEADBEEF);
    chk("after collision rf", g0[1], 32'hDEADBEEF);
    chk("after collision wf", g1[1], 32'hDEADBEEF);

    // Backpressure on port 1 during a 6-read burst on both ports
    for (int i = 0; i < 6; i++) wr(10 + i, 32'h1000_0000 + 32'(i), 4'hF);
    rec_en = 1'b1;
    tick();
    i0 = 0; i1 = 0;
    for (int c = 0; c < 40 && (rec_n[0] < 6 || rec_n[1] < 6); c++) begin
      s_rd_dready = {!(c >= 3 && c < 7), 1'b1};
      s_rd_valid = {i1 < 6, i0 < 6};
      s_rd_addr = {5'(10 + i1), 5'(10 + i0)};
      #1;
      a0 = s_rd_valid[0] && b0.rd_ready[0];
      a1 = s_rd_valid[1] && b0.rd_ready[1];
      if (c == 4) begin
        chk("bp rd_ready1 stalled", 32'(b0.rd_ready[1]), 32'h0);
        chk("bp rd_ready0 free", 32'(b0.rd_ready[0]), 32'h1);
      end
      tick();
      if (a0) i0++;
      if (a1) i1++;
    end
    s_rd_valid = '0; s_rd_dready = '1;
    chk("bp p0 count", 32'(rec_n[0]), 32'h6);
    chk("bp p1 count", 32'(rec_n[1]), 32'h6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp p0 word%0d", i), rec[0][i], 32'h1000_0000 + 32'(i));
      chk($sformatf("bp p1 word%0d", i), rec[1][i], 32'h1000_0000 + 32'(i));
    end
    rec_en = 1'b0;
    tick();

    // Out-of-range write and read
    chk("addr_err before", 32'(b0.addr_err), 32'h0);
    wr(25, 32'h5555AAAA, 4'hF);
    chk("addr_err after wr rf", 32'(b0.addr_err), 32'h1);
    chk("addr_err after wr wf", 32'(b1.addr_err), 32'h1);
    rd(1, 25);
    collect(1, 1);
    chk("oor read rf", g0[0], 32'h0);
    chk("oor read wf", g1[0], 32'h0);
    rd(0, 5);
    collect(0, 1);
    chk("mem intact after oor", g0[0], 32'hAA22CC44);

    random_traffic(400);

    // Reset mid-operation with reads in flight
    wr(2, 32'hCAFEF00D, 4'hF);
    s_rd_valid = 2'b11; s_rd_addr = {5'd2, 5'd2};
    tick(); tick(); tick();
    rst_n = 1'b0; s_rd_valid = '0;
    tick();
    chk("mid rst dv rf", 32'(b0.rd_data_valid), 32'h0);
    chk("mid rst dv wf", 32'(b1.rd_data_valid), 32'h0);
    chk("mid rst addr_err", 32'(b0.addr_err), 32'h0);
    rst_n = 1'b1;
    wait_init("second");
    rd(0, 2);
    collect(0, 1);
    chk("post reset data rf", g0[0], 32'h0);
    chk("post reset data wf", g1[0], 32'h0);

    random_traffic(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
